// File: rtl/alu_add_arbiter.sv
// -----------------------------------------------------------------------------
// alu_add_arbiter
//   Shares one DATA_W-bit adder among NUM_REQ requesters. A round-robin
//   arbiter picks one pending requester while idle, latches its operand pair,
//   adds it in the following cycle and pulses that requester's ack while the
//   registered sum and signed-overflow flag are presented on out/overflow.
//   One transaction occupies three cycles: IDLE -> EXEC -> DONE -> IDLE.
//
// Ports
//   clk       sole clock, rising edge
//   reset     asynchronous, active-high reset
//   req       per-requester add request (level, held until ack)
//   in_0      packed operand 0, requester i at [i*DATA_W +: DATA_W]
//   in_1      packed operand 1, same packing
//   grant     one-hot owner of the adder, zero when idle
//   ack       one-hot single-cycle pulse: out/overflow valid for that owner
//   out       registered sum (modulo 2^DATA_W)
//   overflow  registered two's-complement overflow of out
//   busy      high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module alu_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 24
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] in_0,
  input  logic [NUM_REQ*DATA_W-1:0] in_1,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         out,
  output logic                      overflow,
  output logic                      busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic                ovf_q, ovf_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   op0_q, op0_d;
  logic [DATA_W-1:0]   op1_q, op1_d;

  // ---------------------------------------------------------------------------
  // Round-robin pick: first requester at or after ptr_q, wrapping to 0.
  // ---------------------------------------------------------------------------
  logic             found;
  logic [PTR_W-1:0] win_idx;

  always_comb begin : arb
    int cand;
    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned; that is what keeps a latch from being inferred.
    found   = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = int'(ptr_q) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req[cand]) begin
        found   = 1'b1;
        win_idx = PTR_W'(cand);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Adder with sign-bit overflow rule; carry-out is simply dropped.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] sum;
  logic              sum_ovf;

  assign sum     = op0_q + op1_q;
  assign sum_ovf = (op0_q[DATA_W-1] == op1_q[DATA_W-1]) &&
                   (sum[DATA_W-1]   != op0_q[DATA_W-1]);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    ack_d   = ack_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    op0_d   = op0_q;
    op1_d   = op1_q;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          // Operands are captured only here, so later input changes are ignored.
          op0_d   = in_0[int'(win_idx)*DATA_W +: DATA_W];
          op1_d   = in_1[int'(win_idx)*DATA_W +: DATA_W];
          grant_d = NUM_REQ'(1) << win_idx;
          ptr_d   = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + PTR_W'(1);
          busy_d  = 1'b1;
          state_d = EXEC;
        end
      end

      EXEC: begin
        out_d   = sum;
        ovf_d   = sum_ovf;
        ack_d   = grant_q;
        state_d = DONE;
      end

      DONE: begin
        // out/overflow keep their value until the next EXEC.
        ack_d   = '0;
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        ack_d   = '0;
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the operand latches are reset along with the control state; they
      // are just two words, and a defined value keeps out deterministic.
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      op0_q   <= '0;
      op1_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      op0_q   <= op0_d;
      op1_q   <= op1_d;
    end
  end

  assign grant    = grant_q;
  assign ack      = ack_q;
  assign out      = out_q;
  assign overflow = ovf_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_alu_add_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_add_arbiter
//   Self-checking bench for alu_add_arbiter. A transaction-level reference
//   model (phase counter, integer pointer, signed integer arithmetic) predicts
//   grant/ack/busy/out/overflow every cycle. Directed scenarios cover the
//   documented examples, followed by a randomized run with random resets.
// -----------------------------------------------------------------------------
module tb_alu_add_arbiter;

  localparam int N  = 4;
  localparam int DW = 24;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req;
  logic [N*DW-1:0]   in_0, in_1;
  logic [N-1:0]      grant, ack;
  logic [DW-1:0]     out;
  logic              overflow;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_phase;   // 0 idle, 1 operation granted, 2 result presented
  int          m_ptr;
  int          m_owner;
  logic [DW-1:0] m_a, m_b, m_out;
  logic        m_ovf;

  alu_add_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .in_0     (in_0),
    .in_1     (in_1),
    .grant    (grant),
    .ack      (ack),
    .out      (out),
    .overflow (overflow),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  task automatic model_reset();
    m_phase = 0;
    m_ptr   = 0;
    m_owner = 0;
    m_out   = '0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_edge();
    longint sa, sb, s, lim;
    case (m_phase)
      0: if (req != '0) begin
        for (int k = 0; k < N; k++) begin
          int c = (m_ptr + k) % N;
          if (req[c]) begin
            m_owner = c;
            break;
          end
        end
        m_a     = in_0[m_owner*DW +: DW];
        m_b     = in_1[m_owner*DW +: DW];
        m_ptr   = (m_owner + 1) % N;
        m_phase = 1;
      end
      1: begin
        m_out = m_a + m_b;
        sa    = longint'($signed(m_a));
        sb    = longint'($signed(m_b));
        s     = sa + sb;
        lim   = longint'(1) << (DW - 1);
        m_ovf = (s > lim - 1) || (s < -lim);
        m_phase = 2;
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic model_compare();
    logic [N-1:0] eg, ea;
    eg = (m_phase != 0) ? N'(1) << m_owner : '0;
    ea = (m_phase == 2) ? N'(1) << m_owner : '0;
    check("grant",    grant,    eg);
    check("ack",      ack,      ea);
    check("busy",     busy,     m_phase != 0);
    check("out",      out,      m_out);
    check("overflow", overflow, m_ovf);
  endtask

  // Called at a falling edge: apply req, clock once, compare at the next fall.
  task automatic step(input logic [N-1:0] r);
    req = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    model_compare();
  endtask

  task automatic set_ops(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    in_0[i*DW +: DW] = a;
    in_1[i*DW +: DW] = b;
  endtask

  // Called at a falling edge; checks the asynchronous clear before any edge.
  task automatic reset_pulse();
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_grant",    grant,    '0);
    check("rst_ack",      ack,      '0);
    check("rst_out",      out,      '0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_busy",     busy,     1'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic add_once(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] exp_out, input logic exp_ovf);
    set_ops(i, a, b);
    step(N'(1) << i);
    check("add_grant", grant, N'(1) << i);
    step('0);
    check("add_ack", ack, N'(1) << i);
    check("add_out", out, exp_out);
    check("add_ovf", overflow, exp_ovf);
    step('0);
    check("add_idle", busy, 1'b0);
  endtask

  function automatic logic [DW-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 24'h7FFFFF;
      1:       return 24'h800000;
      2:       return 24'hFFFFFF;
      3:       return 24'h000001;
      4:       return 24'h000000;
      default: return DW'($urandom);
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    req   = '0;
    in_0  = '0;
    in_1  = '0;
    model_reset();
    #2;
    check("init_grant", grant, '0);
    check("init_busy",  busy,  1'b0);
    check("init_out",   out,   '0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Single request with fixed latency, then out holds while idle.
    set_ops(0, 24'h000005, 24'h000003);
    step(4'b0001);
    check("single_grant", grant, 4'b0001);
    check("single_ack0",  ack,   4'b0000);
    step(4'b0000);
    check("single_ack",   ack,   4'b0001);
    check("single_out",   out,   24'h000008);
    check("single_ovf",   overflow, 1'b0);
    step(4'b0000);
    check("single_busy",  busy,  1'b0);
    step(4'b0000);
    check("single_hold",  out,   24'h000008);

    // Overflow corner cases.
    add_once(1, 24'h7FFFFF, 24'h000001, 24'h800000, 1'b1);
    add_once(2, 24'h800000, 24'hFFFFFF, 24'h7FFFFF, 1'b1);
    add_once(3, 24'hFFFFFF, 24'h000001, 24'h000000, 1'b0);

    // Operands changed right after grant must not affect the result.
    set_ops(0, 24'h000005, 24'h000003);
    step(4'b0001);
    in_0[0 +: DW] = 24'h100000;
    step(4'b0000);
    check("stable_out", out, 24'h000008);
    step(4'b0000);

    // Round-robin order with all requests held from reset.
    reset_pulse();
    for (int i = 0; i < N; i++) set_ops(i, DW'(i + 1), DW'(16 * i));
    for (int k = 0; k < 5; k++) begin
      step(4'b1111);
      check("rr_grant", grant, N'(1) << (k % N));
      step(4'b1111);
      step(4'b1111);
    end

    // Wrap fairness: after granting 0100, req=1001 goes 1000 then 0001.
    reset_pulse();
    step(4'b0100);
    check("wrap_g2", grant, 4'b0100);
    step(4'b0000);
    step(4'b0000);
    step(4'b1001);
    check("wrap_g3", grant, 4'b1000);
    step(4'b1001);
    step(4'b1001);
    step(4'b1001);
    check("wrap_g0", grant, 4'b0001);
    step(4'b0000);
    step(4'b0000);

    // Reset during EXEC abandons the operation and resets the pointer.
    reset_pulse();
    step(4'b0001);
    step(4'b0000);
    step(4'b0000);
    step(4'b0010);
    check("rexec_grant", grant, 4'b0010);
    reset_pulse();
    step(4'b0011);
    check("rexec_after", grant, 4'b0001);
    check("rexec_noack", ack,   4'b0000);
    step(4'b0000);
    step(4'b0000);

    // Randomized traffic with occasional resets.
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < N; i++) set_ops(i, pick_operand(), pick_operand());
      if ($urandom_range(0, 60) == 0) reset_pulse();
      step(N'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
